// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// 8N1 serial receiver with mid-bit sampling, stop-bit check and a show-ahead
// byte FIFO behind a valid/ready handshake.
//
// Ports:
//   uart_clk    receive clock, all logic on the rising edge
//   nrst        synchronous active-low reset
//   rx_in       asynchronous serial line, idle high
//   m_data      byte at the FIFO head (meaningful only while m_valid=1)
//   m_valid     FIFO not empty
//   m_ready     consumer accepts the head byte
//   fifo_count  bytes currently buffered
//   busy        receiver FSM is inside a frame
//   frame_err   one-cycle pulse: stop bit sampled low, byte dropped
//   overrun     one-cycle pulse: good byte dropped because the FIFO was full
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                           uart_clk,
  input  logic                           nrst,
  input  logic                           rx_in,
  output logic [7:0]                     m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           busy,
  output logic                           frame_err,
  output logic                           overrun
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [CNTW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic rx_meta, rx_sync, rx_prev;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic bit_end, half_end, data_sample, stop_sample;
  logic full, push, pop;

  // --------------------------------------------------------------------------
  // Line synchroniser and edge history; idle level is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's old value,
      // forming a real two-stage chain rather than collapsing into one.
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge uart_clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  assign bit_end  = (cnt == BIT_LAST);
  assign half_end = (cnt == HALF_LAST);

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch.
    state_next = state;
    unique case (state)
      // Only a true 1->0 transition starts a frame, so a stuck-low line
      // never retriggers.
      IDLE:  if (rx_prev && !rx_sync) state_next = START;
      START: if (half_end)            state_next = rx_sync ? IDLE : DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_end)             state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / strobes
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (state != IDLE);
    data_sample = (state == DATA) && bit_end;
    stop_sample = (state == STOP) && bit_end;
  end

  // --------------------------------------------------------------------------
  // Bit timing counter, bit index and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE:  cnt <= '0;
        START: cnt <= half_end ? '0 : cnt + 1'b1;
        default: cnt <= bit_end ? '0 : cnt + 1'b1;
      endcase
      if (state == START && half_end) bit_idx <= '0;
      else if (data_sample)           bit_idx <= bit_idx + 1'b1;
      if (data_sample) shreg[bit_idx] <= rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Byte FIFO. Full is judged on the pre-pop count, so a push arriving while
  // full is dropped even if the consumer pops on the same edge.
  // --------------------------------------------------------------------------
  assign full = (count == FULL_CNT);
  assign push = stop_sample && rx_sync && !full;
  assign pop  = m_valid && m_ready;

  // NOTE: storage has no reset; pointers and count define which entries are
  // live, so clearing the array would only cost logic.
  always_ff @(posedge uart_clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_err <= stop_sample && !rx_sync;
      overrun   <= stop_sample && rx_sync && full;
    end
  end

  assign m_data     = mem[rd_ptr];
  assign m_valid    = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed testbench for uart_rx_deframer with default parameters
// (16 clocks per bit, 8-entry FIFO). Stimulus and sampling happen on the
// falling clock edge; the DUT works on the rising edge.
module tb_uart_rx_deframer;

  logic       uart_clk = 1'b0;
  logic       nrst     = 1'b0;
  logic       rx_in    = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready  = 1'b0;
  logic [3:0] fifo_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_cnt = 0;

  uart_rx_deframer #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
    .uart_clk   (uart_clk),
    .nrst       (nrst),
    .rx_in      (rx_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 uart_clk = ~uart_clk;

  // Pulse and busy-cycle counters, sampled mid-cycle.
  always @(negedge uart_clk) begin
    if (frame_err) fe_cnt   <= fe_cnt + 1;
    if (overrun)   ov_cnt   <= ov_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge uart_clk);
  endtask

  // One 8N1 frame, 16 clocks per bit; stop_bit lets a frame error be forced.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (16) @(negedge uart_clk);
    end
  endtask

  int fe0, ov0, bz0;

  initial begin
    // ---------------- reset state ----------------
    idle(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    nrst = 1'b1;
    idle(5);

    // ---------------- 0x55, exact latency ----------------
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        idle(154);
        check("lat_before", m_valid, 0);
        idle(1);
        check("lat_after", m_valid, 1);
      end
    join
    check("b55_data", m_data, 8'h55);
    check("b55_count", fifo_count, 1);
    check("b55_fe", fe_cnt - fe0, 0);
    check("b55_ov", ov_cnt - ov0, 0);
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    check("b55_drained", m_valid, 0);
    idle(10);

    // ---------------- 4-cycle glitch ----------------
    fe0 = fe_cnt; ov0 = ov_cnt; bz0 = busy_cnt;
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(30);
    check("glitch_busy_cycles", busy_cnt - bz0, 8);
    check("glitch_valid", m_valid, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_ov", ov_cnt - ov0, 0);

    // ---------------- frame error, line stuck low ----------------
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    idle(40);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_count", fifo_count, 0);
    check("fe_no_retrigger", busy, 0);
    rx_in = 1'b1;
    idle(20);

    // ---------------- fill to full, then overrun ----------------
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    check("full_count", fifo_count, 8);
    send_frame(8'h09, 1'b1);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_count", fifo_count, 8);
    check("ovr_head", m_data, 8'h01);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), m_data, 32'(i));
      check($sformatf("drain_valid_%0d", i), m_valid, 1);
      idle(1);
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);
    check("drain_count", fifo_count, 0);
    idle(10);

    // ---------------- simultaneous push and pop ----------------
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    check("pp_count_pre", fifo_count, 4);
    fork
      send_frame(8'h14, 1'b1);
      begin
        idle(154);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        check("pp_count", fifo_count, 4);
        check("pp_head", m_data, 8'h11);
      end
    join
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("pp_order_%0d", i), m_data, 32'h10 + 32'(i));
      idle(1);
    end
    m_ready = 1'b0;
    check("pp_empty", m_valid, 0);
    idle(10);

    // ---------------- reset mid-DATA ----------------
    for (int i = 0; i < 3; i++) send_frame(8'h20 + 8'(i), 1'b1);
    check("rstm_count_pre", fifo_count, 3);
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1);  // line high while reset is applied
      begin
        idle(60);
        check("rstm_busy_pre", busy, 1);
        nrst = 1'b0;
        idle(1);
        nrst = 1'b1;
        check("rstm_busy", busy, 0);
        check("rstm_count", fifo_count, 0);
        check("rstm_valid", m_valid, 0);
      end
    join
    idle(20);
    send_frame(8'hC3, 1'b1);
    check("c3_data", m_data, 8'hC3);
    check("c3_count", fifo_count, 1);
    check("c3_fe", fe_cnt - fe0, 0);
    check("c3_ov", ov_cnt - ov0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
